bcd_decoder_drv: RTL and testbench
==================================

# bcd_decoder_drv

Registered 2-to-4 one-hot decoder with a handshake and a programmable hold time. It is the receive-side counterpart of the team's 4-to-2 priority encoder. It accepts a 2-bit code plus valid flag, drives exactly one of four one-hot lines for a fixed number of cycles, then inserts a one-cycle gap before it accepts the next code. It sits between the encoder output (or any 2-bit code source) and downstream select/strobe lines that need clean, glitch-free, timed one-hot pulses.

## Interface
- HOLD_CYCLES, 4, number of cycles the selected one-hot line stays high; legal range 1..255 (0 is illegal, elaboration check required)
- CNT_W, 8, hold-counter width; must satisfy 2^CNT_W > HOLD_CYCLES

- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset; sampled on rising edge of clk
- Y  input  2  code to decode (00→O0, 01→O1, 10→O2, 11→O3)
- valid  input  1  code-valid qualifier from source
- ready  output  1  high when block can accept a code
- O0, O1, O2, O3  output  1 each  registered one-hot outputs
- busy  output  1  high while in DRIVE or GAP
- done  output  1  one-cycle pulse marking end of a hold period
- clr_ovr  input  1  clears the overrun flag
- overrun  output  1  sticky: valid seen while ready low

## Operation
- States: IDLE, DRIVE, GAP. Reset state is IDLE.
- IDLE:
  - ready=1; O0..O3=0; busy=0.
  - If valid=1, the code is accepted: Y is latched, the counter is loaded with HOLD_CYCLES-1, and the next state is DRIVE.
- DRIVE:
  - Exactly one O line is high, selected by the latched code; ready=0; busy=1.
  - Counter decrements each cycle. When counter=0, the next state is GAP.
  - Y changes during DRIVE have no effect.
- GAP:
  - O0..O3=0; ready=0; busy=1; done=1 for this single cycle.
  - Next state is IDLE unconditionally.
- Overrun:
  - Any cycle with valid=1 and ready=0 sets overrun on the next edge.
  - overrun stays set until clr_ovr=1. Set has priority over clear in the same cycle.
  - A valid during an overrun cycle is dropped and is never queued.
- One-hot guarantee: at most one O line is high in any cycle, and all are 0 outside DRIVE. Outputs come directly from flops, with no combinational path from Y or valid to O.
- ready is a pure function of state and does not depend on valid.
- Reset values (rst_n=0 at an edge): state=IDLE, O0..O3=0, busy=0, done=0, overrun=0, counter=0, latched code=00. ready=1 on the cycle after reset releases.
- Reset mid-DRIVE or mid-GAP aborts immediately. No done pulse is produced for the aborted code.

## Timing
- Acceptance edge t: valid=1 and ready=1 sampled at edge t.
- O[code] is high for cycles t+1 .. t+HOLD_CYCLES (exactly HOLD_CYCLES cycles).
- done=1 and all O=0 during cycle t+HOLD_CYCLES+1 (GAP).
- ready=1 again from cycle t+HOLD_CYCLES+2. Minimum code-to-code spacing is HOLD_CYCLES+2 cycles.
- HOLD_CYCLES=1 gives one cycle of DRIVE, then GAP, then IDLE: 3-cycle spacing.
- A valid held high continuously is accepted at every IDLE cycle. It also sets overrun, because it is present during DRIVE/GAP.
- overrun rises one cycle after the offending valid. clr_ovr takes effect at the next edge.

## Test plan
- Reset and idle: hold rst_n=0 for 3 cycles, then release → O0..O3=0, busy=0, done=0, overrun=0; ready=1 on the first cycle after release.
- Single decode with HOLD_CYCLES=4: pulse valid=1 with Y=10 for one cycle at edge t → O2=1 for cycles t+1..t+4 with O0/O1/O3=0; done=1 only at t+5; ready=1 at t+6; overrun stays 0.
- All codes back-to-back: present Y=00,01,10,11, each raising valid exactly when ready=1 → O0,O1,O2,O3 each high 4 cycles in order; 4 done pulses; never two O lines high at once; overrun=0.
- Overrun and clear: valid=1 with Y=01 at t, then valid=1 with Y=11 at t+2 → O1 driven as normal; O3 never rises for that request; overrun=1 from t+3. Then assert clr_ovr=1 for one cycle with valid=0 → overrun=0 the following cycle. Next, assert clr_ovr=1 and an overrunning valid in the same cycle → overrun stays 1.
- Reset mid-operation: accept Y=11 and, on the second DRIVE cycle, drive rst_n=0 for 1 cycle → O3=0 and busy=0 the next cycle; no done pulse; ready=1 after release.
- HOLD_CYCLES=1 build with valid tied high and Y=01 → O1 high 1 cycle out of every 3; a done pulse every 3 cycles; overrun=1 from the 2nd cycle after the first acceptance.

Source files
------------

// File: rtl/bcd_decoder_drv.sv
// Registered 2-to-4 one-hot decoder with valid/ready acceptance,
// programmable hold time, a one-cycle gap, and a sticky overrun flag.
module bcd_decoder_drv #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] Y,
  input  logic       valid,
  output logic       ready,
  output logic       O0,
  output logic       O1,
  output logic       O2,
  output logic       O3,
  output logic       busy,
  output logic       done,
  input  logic       clr_ovr,
  output logic       overrun
);

  generate
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255 ||
        (64'd1 << CNT_W) <= 64'(HOLD_CYCLES)) begin : g_bad_cfg
      $error("bcd_decoder_drv: illegal HOLD_CYCLES/CNT_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    GAP
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [1:0]       code;
  logic [1:0]       code_n;
  logic [3:0]       o_q;
  logic [3:0]       o_n;
  logic             busy_q;
  logic             busy_n;
  logic             done_q;
  logic             done_n;
  logic             ovr_q;
  logic             ovr_n;

  assign ready = (state == IDLE);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    code_n  = code;
    unique case (state)
      IDLE: begin
        if (valid) begin
          code_n  = Y;
          cnt_n   = CNT_W'(HOLD_CYCLES - 1);
          state_n = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt == '0) state_n = GAP;
        else           cnt_n   = cnt - CNT_W'(1);
      end
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // Outputs are registered from the next state so O never sees Y/valid.
    o_n    = (state_n == DRIVE) ? (4'b0001 << code_n) : 4'b0000;
    busy_n = (state_n != IDLE);
    done_n = (state_n == GAP);
    if (valid && !ready) ovr_n = 1'b1;
    else if (clr_ovr)    ovr_n = 1'b0;
    else                 ovr_n = ovr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      code   <= 2'b00;
      o_q    <= 4'b0000;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      code   <= code_n;
      o_q    <= o_n;
      busy_q <= busy_n;
      done_q <= done_n;
      ovr_q  <= ovr_n;
    end
  end

  assign O0      = o_q[0];
  assign O1      = o_q[1];
  assign O2      = o_q[2];
  assign O3      = o_q[3];
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_bcd_decoder_drv.sv
// Directed self-checking bench for bcd_decoder_drv
// (HOLD_CYCLES=4 main instance, HOLD_CYCLES=1 streaming instance).
module tb_bcd_decoder_drv;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] Y;
  logic       valid;
  logic       ready;
  logic       O0, O1, O2, O3;
  logic       busy;
  logic       done;
  logic       clr_ovr;
  logic       overrun;

  logic       rst_n2;
  logic       ready2;
  logic       p0, p1, p2, p3;
  logic       busy2;
  logic       done2;
  logic       overrun2;

  int errs = 0;
  int chks = 0;

  always #5 clk = ~clk;

  bcd_decoder_drv #(.HOLD_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .Y(Y), .valid(valid), .ready(ready),
    .O0(O0), .O1(O1), .O2(O2), .O3(O3), .busy(busy), .done(done),
    .clr_ovr(clr_ovr), .overrun(overrun)
  );

  bcd_decoder_drv #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n2), .Y(2'b01), .valid(1'b1), .ready(ready2),
    .O0(p0), .O1(p1), .O2(p2), .O3(p3), .busy(busy2), .done(done2),
    .clr_ovr(1'b0), .overrun(overrun2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    chks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    rst_n2  = 1'b0;
    valid   = 1'b0;
    Y       = 2'b00;
    clr_ovr = 1'b0;

    repeat (3) tick();
    chk("rst_o",    {4'b0, O3, O2, O1, O0}, 8'h0);
    chk("rst_busy", {7'b0, busy},    8'h0);
    chk("rst_done", {7'b0, done},    8'h0);
    chk("rst_ovr",  {7'b0, overrun}, 8'h0);
    chk("rst1_o",   {4'b0, p3, p2, p1, p0}, 8'h0);
    chk("rst1_ovr", {7'b0, overrun2}, 8'h0);
    rst_n = 1'b1;
    tick();
    chk("idle_ready", {7'b0, ready}, 8'h1);
    chk("idle_busy",  {7'b0, busy},  8'h0);

    // single decode of Y=10
    valid = 1'b1;
    Y     = 2'b10;
    tick();
    valid = 1'b0;
    Y     = 2'b01;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("one_o%0d", k), {4'b0, O3, O2, O1, O0}, 8'h4);
      chk($sformatf("one_rb%0d", k), {6'b0, ready, busy}, 8'h1);
      chk($sformatf("one_dn%0d", k), {7'b0, done}, 8'h0);
      tick();
    end
    chk("one_gap_o",  {4'b0, O3, O2, O1, O0}, 8'h0);
    chk("one_gap_dn", {7'b0, done}, 8'h1);
    chk("one_gap_rb", {6'b0, ready, busy}, 8'h1);
    tick();
    chk("one_rdy",  {6'b0, ready, busy}, 8'h2);
    chk("one_dn0",  {7'b0, done},    8'h0);
    chk("one_ovr",  {7'b0, overrun}, 8'h0);

    // all codes back-to-back
    for (int c = 0; c < 4; c++) begin
      valid = 1'b1;
      Y     = 2'(c);
      tick();
      valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        chk($sformatf("b2b_o%0d_%0d", c, k),
            {4'b0, O3, O2, O1, O0}, 8'(1 << c));
        tick();
      end
      chk($sformatf("b2b_gap%0d", c),
          {3'b0, done, O3, O2, O1, O0}, 8'h10);
      tick();
      chk($sformatf("b2b_rdy%0d", c), {7'b0, ready}, 8'h1);
    end
    chk("b2b_ovr", {7'b0, overrun}, 8'h0);

    // overrun: accept Y=01, then a valid Y=11 while busy
    valid = 1'b1;
    Y     = 2'b01;
    tick();
    valid = 1'b0;
    tick();
    valid = 1'b1;
    Y     = 2'b11;
    tick();
    valid = 1'b0;
    chk("ovr_set", {7'b0, overrun}, 8'h1);
    chk("ovr_o_a", {4'b0, O3, O2, O1, O0}, 8'h2);
    tick();
    chk("ovr_o_b", {4'b0, O3, O2, O1, O0}, 8'h2);
    tick();
    chk("ovr_gap", {3'b0, done, O3, O2, O1, O0}, 8'h10);
    tick();
    chk("ovr_idle", {3'b0, ready, O3, O2, O1, O0}, 8'h10);
    tick();
    chk("ovr_noq", {3'b0, busy, O3, O2, O1, O0}, 8'h00);
    chk("ovr_hold", {7'b0, overrun}, 8'h1);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("ovr_clr", {7'b0, overrun}, 8'h0);

    // set beats clear in the same cycle
    valid = 1'b1;
    Y     = 2'b00;
    tick();
    clr_ovr = 1'b1;
    tick();
    valid   = 1'b0;
    clr_ovr = 1'b0;
    chk("ovr_prio", {7'b0, overrun}, 8'h1);
    chk("ovr_prio_o", {4'b0, O3, O2, O1, O0}, 8'h1);
    repeat (4) tick();
    chk("ovr_prio_rdy", {7'b0, ready}, 8'h1);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("ovr_clr2", {7'b0, overrun}, 8'h0);

    // reset during the second DRIVE cycle
    valid = 1'b1;
    Y     = 2'b11;
    tick();
    valid = 1'b0;
    tick();
    chk("mid_o", {4'b0, O3, O2, O1, O0}, 8'h8);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_o",  {4'b0, O3, O2, O1, O0}, 8'h0);
    chk("mid_rst_bd", {6'b0, busy, done}, 8'h0);
    tick();
    chk("mid_rdy", {7'b0, ready}, 8'h1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("mid_nodone%0d", k), {7'b0, done}, 8'h0);
      tick();
    end

    // HOLD_CYCLES=1 with valid tied high and Y=01
    rst_n2 = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk($sformatf("h1_o%0d", k), {4'b0, p3, p2, p1, p0},
          (k % 3 == 0) ? 8'h2 : 8'h0);
      chk($sformatf("h1_dn%0d", k), {7'b0, done2},
          (k % 3 == 1) ? 8'h1 : 8'h0);
      chk($sformatf("h1_ovr%0d", k), {7'b0, overrun2},
          (k >= 1) ? 8'h1 : 8'h0);
    end

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
